dmem_responder: RTL and testbench

- Data-memory responder that services load/store requests issued by the pipeline's memory-access stage.
- Accepts one request at a time over a valid/ready handshake and models a fixed access latency.
- Performs RV32I byte/half/word loads and stores with sign or zero extension and a misalignment error flag.
- Returns each result on a separate valid/ready response channel with backpressure.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder for RV32I loads/stores with a fixed access latency
// and valid/ready request and response channels.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_func3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  we_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, commit, mem_we, c_err;
  logic                  c_we;
  logic [2:0]            c_func3;
  logic [DATA_WIDTH-1:0] c_addr, c_wdata;
  logic [IdxW-1:0]       c_idx;
  logic [1:0]            c_lane;
  logic [DATA_WIDTH-1:0] c_word, c_shift, load_val, store_mask, store_data, store_word;
  logic                  unused_addr;

  assign accept = (state_q == StIdle) && req_valid_i && req_ready_q;
  assign commit = (accept && (LATENCY == 1)) || ((state_q == StWait) && (cnt_q == 4'd1));

  // With LATENCY == 1 the commit happens on the accept edge, so it must see the raw request.
  always_comb begin
    if (state_q == StIdle) begin
      c_we    = req_we_i;
      c_func3 = req_func3_i;
      c_addr  = req_addr_i;
      c_wdata = req_wdata_i;
    end else begin
      c_we    = we_q;
      c_func3 = func3_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  assign c_idx       = c_addr[IdxW+1:2];
  assign c_lane      = c_addr[1:0];
  assign unused_addr = ^c_addr[DATA_WIDTH-1:IdxW+2];
  assign c_word      = mem_q[c_idx];
  assign c_shift     = c_word >> {c_lane, 3'b000};

  always_comb begin
    case (c_func3)
      3'b000:         c_err = 1'b0;
      3'b001, 3'b101: c_err = c_addr[0] | (c_we & c_func3[2]);
      3'b010:         c_err = |c_addr[1:0];
      3'b100:         c_err = c_we;
      default:        c_err = 1'b1;
    endcase
  end

  always_comb begin
    case (c_func3)
      3'b000:  load_val = {{(DATA_WIDTH-8){c_shift[7]}}, c_shift[7:0]};
      3'b001:  load_val = {{(DATA_WIDTH-16){c_shift[15]}}, c_shift[15:0]};
      3'b010:  load_val = c_word;
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, c_shift[7:0]};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, c_shift[15:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    case (c_func3[1:0])
      2'b00:   store_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {c_lane, 3'b000};
      2'b01:   store_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << {c_lane, 3'b000};
      default: store_mask = '1;
    endcase
  end

  assign store_data = c_wdata << {c_lane, 3'b000};
  assign store_word = (c_word & ~store_mask) | (store_data & store_mask);
  assign mem_we     = commit && c_we && !c_err && !rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_we || c_err) ? '0 : load_val;
    end
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      func3_q <= req_func3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[c_idx] <= store_word;
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference memory model.
module tb_dmem_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 256;
  localparam int unsigned Bytes = Depth * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          n_checks = 0;
  int          n_errors = 0;
  bit [7:0]    mb [Bytes];
  logic [31:0] last_rdata;
  logic        last_err;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH(Depth), .LATENCY(Lat)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_func3_i (req_func3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if (f3[1:0] == 2'd1 && (a % 2) != 0) return 1'b1;
    if (f3[1:0] == 2'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] a);
    int unsigned base;
    longint v;
    base = a % Bytes;
    case (f3)
      3'd0, 3'd4: begin
        v = mb[base];
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end
      3'd1, 3'd5: begin
        v = mb[base] + 256 * mb[base + 1];
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end
      default: v = mb[base] + (longint'(mb[base + 1]) << 8) + (longint'(mb[base + 2]) << 16)
                   + (longint'(mb[base + 3]) << 24);
    endcase
    return 32'(v);
  endfunction

  function automatic void model_store(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    int unsigned base, n;
    base = a % Bytes;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[base + i] = 8'(d >> (8 * i));
  endfunction

  // Entered and left at a negedge; keep_valid leaves the request asserted as a pending one.
  task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     input int hold, input bit keep_valid, input bit expect_immediate);
    bit [31:0] er;
    bit        ee;
    int        n;
    ee = model_err(we, f3, a);
    er = (we || ee) ? 32'd0 : model_load(f3, a);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("accept_timeout", 32'(req_ready), 32'd1);
    if (expect_immediate) check("accept_wait", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 50) begin
      check("ready_in_wait", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 32'(n), 32'(Lat));
    if (we && !ee) model_store(f3, a, wd);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", rsp_rdata, er);
      check("hold_err", 32'(rsp_err), 32'(ee));
      @(negedge clk);
    end
    check("rsp_rdata", rsp_rdata, er);
    check("rsp_err", 32'(rsp_err), 32'(ee));
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit [2:0]  f3;
    bit [31:0] a;
    bit        we;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < Depth; w++) txn(1'b1, 3'd2, 32'(w * 4), $urandom, 0, 1'b0, 1'b1);

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b1);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp1_lw", last_rdata, 32'hDEADBEEF);
    txn(1'b1, 3'd0, 32'h13, 32'h000000A5, 0, 1'b0, 1'b1);
    txn(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0, 1'b1);
    check("tp2_lb", last_rdata, 32'hFFFFFFA5);
    txn(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0, 1'b1);
    check("tp2_lbu", last_rdata, 32'h000000A5);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp2_lw", last_rdata, 32'hA5ADBEEF);
    txn(1'b1, 3'd1, 32'h12, 32'h00008001, 0, 1'b0, 1'b1);
    txn(1'b0, 3'd1, 32'h12, 32'h0, 0, 1'b0, 1'b1);
    check("tp3_lh", last_rdata, 32'hFFFF8001);
    txn(1'b0, 3'd5, 32'h12, 32'h0, 0, 1'b0, 1'b1);
    check("tp3_lhu", last_rdata, 32'h00008001);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp3_lw", last_rdata, 32'h8001BEEF);
    txn(1'b0, 3'd2, 32'h11, 32'h0, 0, 1'b0, 1'b1);
    check("tp4_lw_mis", 32'(last_err), 32'd1);
    txn(1'b1, 3'd1, 32'h13, 32'h0000FFFF, 0, 1'b0, 1'b1);
    check("tp4_sh_mis", 32'(last_err), 32'd1);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp4_lw_kept", last_rdata, 32'h8001BEEF);
    txn(1'b0, 3'd3, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp4_bad_f3", 32'(last_err), 32'd1);

    txn(1'b0, 3'd2, 32'h10, 32'h0, 3, 1'b1, 1'b1);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 1'b1);
    check("tp5_pending", last_rdata, 32'h8001BEEF);

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'd2;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("midrst_ready_back", 32'(req_ready), 32'd1);
    txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, 1'b1);

    txn(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 0, 1'b0, 1'b1);
    txn(1'b0, 3'd2, 32'h000, 32'h0, 0, 1'b0, 1'b1);
    check("tp6_wrap", last_rdata, 32'hCAFEF00D);

    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 5) % 7);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      txn(we, f3, a, $urandom, $urandom_range(0, 2), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
